// File: rtl/mem_stage_dcache_if.sv
// Main-memory bus between the data cache (master) and main memory (slave).
//
// Handshake: the master raises out_memReq together with out_memWe,
// out_memAddr and out_memWData and holds all four constant until the cycle
// in which the slave pulses inp_memAck (inclusive). inp_memAck is a
// one-cycle completion pulse and may arrive in the very first request
// cycle. inp_memRData is valid only in the ack cycle of a read. The master
// drops out_memReq in the cycle after the ack.
interface mem_stage_dcache_if #(
  parameter int DATA_W = 16
);
  logic              out_memReq;
  logic              out_memWe;
  logic [15:0]       out_memAddr;
  logic [DATA_W-1:0] out_memWData;
  logic              inp_memAck;
  logic [DATA_W-1:0] inp_memRData;

  modport master (
    output out_memReq, out_memWe, out_memAddr, out_memWData,
    input  inp_memAck, inp_memRData
  );

  modport slave (
    input  out_memReq, out_memWe, out_memAddr, out_memWData,
    output inp_memAck, inp_memRData
  );
endinterface

// File: rtl/mem_stage_dcache.sv
// Data-memory stage: direct-mapped, word-addressed, write-through,
// no-write-allocate data cache in front of a multi-cycle main memory.
// out_hit=1 means the access is complete (or there is none); MEM/RB
// latches only then.
module mem_stage_dcache #(
  parameter int INDEX_BITS = 3,
  parameter int DATA_W     = 16
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic [15:0]       inp_address,
  input  logic [DATA_W-1:0] inp_writeData,
  input  logic              inp_memRead,
  input  logic              inp_memWrite,
  output logic              out_hit,
  output logic [DATA_W-1:0] out_readMem,
  mem_stage_dcache_if.master mem_bus,
  output logic [15:0]       out_missCount,
  output logic [1:0]        out_dbgState
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_WR_THRU = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];
  logic [DATA_W-1:0] capture_q, capture_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  lookup_hit;
  logic                  is_store;
  logic                  is_load;

  assign index      = inp_address[INDEX_BITS-1:0];
  assign tag        = inp_address[15:INDEX_BITS];
  assign lookup_hit = valid_q[index] && (tag_q[index] == tag);
  // A simultaneous read and write is treated as a store.
  assign is_store   = inp_memWrite;
  assign is_load    = inp_memRead & ~inp_memWrite;

  // Next-state, line update and counter logic for the miss/write-through FSM.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    capture_d  = capture_q;
    miss_cnt_d = miss_cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          state_d = S_WR_THRU;
          req_d   = 1'b1;
          we_d    = 1'b1;
        end else if (is_load && !lookup_hit) begin
          state_d = S_RD_MISS;
          req_d   = 1'b1;
          we_d    = 1'b0;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_RD_MISS: begin
        if (mem_bus.inp_memAck) begin
          // Conflicting line is simply replaced: write-through means it is clean.
          valid_d[index] = 1'b1;
          tag_d[index]   = tag;
          data_d[index]  = mem_bus.inp_memRData;
          capture_d      = mem_bus.inp_memRData;
          req_d          = 1'b0;
          state_d        = S_DONE;
        end
      end
      S_WR_THRU: begin
        if (mem_bus.inp_memAck) begin
          // No allocation on a store miss; only a resident line is refreshed.
          if (lookup_hit) data_d[index] = inp_writeData;
          capture_d = '0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state with synchronous reset; any in-flight request is abandoned.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      capture_q  <= '0;
      miss_cnt_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      capture_q  <= capture_d;
      miss_cnt_q <= miss_cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
    end
  end

  // Tag/data arrays need no reset; valid bits gate them. Frozen during reset.
  always_ff @(posedge inp_clk) begin
    if (!inp_rst) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Pipeline-facing outputs; read hits return data in the same cycle.
  always_comb begin
    out_hit     = 1'b1;
    out_readMem = '0;
    case (state_q)
      S_IDLE: begin
        out_hit = ~(is_store | (is_load & ~lookup_hit));
        if (is_load && lookup_hit) out_readMem = data_q[index];
      end
      S_RD_MISS, S_WR_THRU: out_hit = 1'b0;
      default: out_readMem = capture_q;
    endcase
    if (inp_rst) begin
      out_hit     = 1'b1;
      out_readMem = '0;
    end
  end

  assign mem_bus.out_memReq   = req_q & ~inp_rst;
  assign mem_bus.out_memWe    = we_q & ~inp_rst;
  // Pipeline holds its inputs during a stall, so these stay constant.
  assign mem_bus.out_memAddr  = inp_address;
  assign mem_bus.out_memWData = inp_writeData;
  assign out_missCount        = miss_cnt_q;
  assign out_dbgState         = state_q;
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed plan plus random loads/stores,
// a main-memory responder, and a queue-based scoreboard.
module tb_mem_stage_dcache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tb_addr = '0;
  logic [15:0] tb_wd = '0;
  logic        tb_rd = 1'b0;
  logic        tb_wr = 1'b0;
  logic        out_hit;
  logic [15:0] out_readMem;
  logic [15:0] out_missCount;
  logic [1:0]  out_dbgState;

  mem_stage_dcache_if #(.DATA_W(16)) bus ();

  mem_stage_dcache #(.INDEX_BITS(3), .DATA_W(16)) dut (
    .inp_clk       (clk),
    .inp_rst       (rst),
    .inp_address   (tb_addr),
    .inp_writeData (tb_wd),
    .inp_memRead   (tb_rd),
    .inp_memWrite  (tb_wr),
    .out_hit       (out_hit),
    .out_readMem   (out_readMem),
    .mem_bus       (bus),
    .out_missCount (out_missCount),
    .out_dbgState  (out_dbgState)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Main-memory responder
  logic [15:0] mem_arr [logic [15:0]];
  int          cur_delay = 0;
  bit          mm_busy = 0;
  int          mm_cnt = 0;
  logic [15:0] mm_addr, mm_wd;
  logic        mm_we;

  initial begin
    bus.inp_memAck   = 1'b0;
    bus.inp_memRData = '0;
    forever begin
      @(negedge clk);
      if (bus.inp_memAck) begin
        bus.inp_memAck = 1'b0;
        continue;
      end
      if (mm_busy && bus.out_memReq) begin
        check("hold_addr", bus.out_memAddr, mm_addr);
        check("hold_we", bus.out_memWe, mm_we);
        if (mm_we) check("hold_wdata", bus.out_memWData, mm_wd);
      end
      if (!mm_busy && bus.out_memReq) begin
        mm_busy = 1;
        mm_cnt  = 0;
        mm_addr = bus.out_memAddr;
        mm_we   = bus.out_memWe;
        mm_wd   = bus.out_memWData;
      end
      if (mm_busy) begin
        if (mm_cnt >= cur_delay) begin
          bus.inp_memAck = 1'b1;
          if (mm_we) begin
            mem_arr[mm_addr] = mm_wd;
            bus.inp_memRData = $urandom_range(0, 16'hFFFF);
          end else begin
            bus.inp_memRData = mem_arr.exists(mm_addr) ? mem_arr[mm_addr] : init_val(mm_addr);
          end
          mm_busy = 0;
        end else begin
          mm_cnt++;
        end
      end
    end
  end

  // Reference model: which word each line holds, plus a flat memory image.
  logic [15:0] ref_mem [logic [15:0]];
  bit          m_valid [8];
  logic [15:0] m_addr  [8];
  logic [15:0] model_mc = 0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Scoreboard queues
  logic [15:0] exp_q[$];
  int          exp_stall_q[$];
  logic [15:0] exp_mc_q[$];

  bit mon_en = 1'b0;
  int stall = 0;

  // Monitor: pops one expectation per completed access
  always @(negedge clk) begin
    if (!mon_en) begin
      stall = 0;
    end else if (tb_rd || tb_wr) begin
      if (bus.out_memReq) begin
        check("req_addr", bus.out_memAddr, tb_addr);
        check("req_we", bus.out_memWe, tb_wr);
      end
      if (!out_hit) begin
        stall++;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: completion with no expectation at %0t", $time);
        end else begin
          check("read_data", out_readMem, exp_q.pop_front());
          check("stall_cycles", stall, exp_stall_q.pop_front());
          check("miss_count", out_missCount, exp_mc_q.pop_front());
        end
        stall = 0;
      end
    end else begin
      check("idle_hit", out_hit, 1'b1);
      check("idle_rdata", out_readMem, 16'h0000);
      check("idle_req", bus.out_memReq, 1'b0);
    end
  end

  // Driver: model first, then present the access and hold until out_hit.
  task automatic access(input logic [15:0] a, input logic [15:0] wd,
                        input bit rd, input bit wr, input int dly);
    int idx;
    bit done;
    idx = int'(a[2:0]);
    if (wr) begin
      ref_mem[a] = wd;
      exp_q.push_back(16'h0000);
      exp_stall_q.push_back(dly + 2);
    end else if (m_valid[idx] && m_addr[idx] == a) begin
      exp_q.push_back(ref_rd(a));
      exp_stall_q.push_back(0);
    end else begin
      if (model_mc != 16'hFFFF) model_mc = model_mc + 1;
      m_valid[idx] = 1;
      m_addr[idx]  = a;
      exp_q.push_back(ref_rd(a));
      exp_stall_q.push_back(dly + 2);
    end
    exp_mc_q.push_back(model_mc);
    @(posedge clk);
    #1;
    tb_addr   = a;
    tb_wd     = wd;
    tb_rd     = rd;
    tb_wr     = wr;
    cur_delay = dly;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (out_hit) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %h never completed", a);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    tb_rd = 0;
    tb_wr = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_addr[i]  = '0;
    end
    mem_arr[16'h0012] = 16'hBEEF;
    ref_mem[16'h0012] = 16'hBEEF;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hit", out_hit, 1'b1);
    check("rst_req", bus.out_memReq, 1'b0);
    check("rst_we", bus.out_memWe, 1'b0);
    check("rst_rdata", out_readMem, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_misscount", out_missCount, 16'h0000);
    mon_en = 1'b1;

    // Directed plan
    access(16'h0012, 16'h0000, 1, 0, 1);   // miss, 3 stalled cycles, BEEF
    access(16'h0012, 16'h0000, 1, 0, 0);   // hit
    access(16'h0012, 16'h1234, 0, 1, 2);   // store hit
    access(16'h0012, 16'h0000, 1, 0, 3);   // hit returns 1234
    idle(2);
    access(16'h0033, 16'h5555, 0, 1, 1);   // store miss, no allocate
    access(16'h0033, 16'h0000, 1, 0, 0);   // load miss, ack in first req cycle
    access(16'h001A, 16'h0000, 1, 0, 2);   // same index as 0012, replaces it
    access(16'h0012, 16'h0000, 1, 0, 1);   // misses again
    access(16'h0012, 16'hAAAA, 1, 1, 0);   // read+write is a store
    access(16'h0012, 16'h0000, 1, 0, 0);   // hit returns AAAA
    idle(1);

    // Random traffic over 32 words (4 tags per index)
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      int kind;
      a    = 16'(($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      access(a, 16'($urandom_range(0, 16'hFFFF)), kind != 2, kind >= 2,
             $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    check("sb_drained", exp_q.size(), 0);

    // Reset in the middle of a read miss; the late ack must be ignored.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    tb_addr   = 16'h7777;
    tb_rd     = 1;
    tb_wr     = 0;
    cur_delay = 4;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.out_memReq) seen = 1;
      end
      check("mid_req_seen", seen, 1'b1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", bus.out_memReq, 1'b0);
    check("mid_rst_hit", out_hit, 1'b1);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    tb_rd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_req", bus.out_memReq, 1'b0);
      check("post_rst_hit", out_hit, 1'b1);
      check("post_rst_rdata", out_readMem, 16'h0000);
    end
    check("post_rst_misscount", out_missCount, 16'h0000);
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    model_mc = 0;
    mon_en = 1'b1;
    access(16'h0012, 16'h0000, 1, 0, 0);   // lines invalid: misses, count 1
    access(16'h0012, 16'h0000, 1, 0, 0);   // now hits
    idle(2);
    check("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
- Data-memory stage of the 16-bit pipeline. Sits directly upstream of the MEM/RB pipeline register.
- Serves loads and stores from a small direct-mapped, word-addressed, write-through, no-write-allocate data cache.
- Talks to a multi-cycle main memory through a req/ack handshake.
- Drives the hit/stall flag and read data consumed by MEM/RB. MEM/RB latches only when hit=1.

Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 one-word lines); tag = inp_address[15:INDEX_BITS].
- DATA_W, 16, data word width.

Ports:
- inp_clk  in  1  clock. All state updates on the rising edge; outputs are stable by the falling edge, where MEM/RB samples.
- inp_rst  in  1  synchronous active-high reset.
- inp_address  in  16  word address (ALU result).
- inp_writeData  in  DATA_W  store data.
- inp_memRead  in  1  load request.
- inp_memWrite  in  1  store request.
- out_hit  out  1  1 = access complete or no access; 0 = stall (pipeline holds inputs stable).
- out_readMem  out  DATA_W  load data, valid when out_hit=1 for a load.
- out_memReq  out  1  main-memory request.
- out_memWe  out  1  1 = write, 0 = read.
- out_memAddr  out  16  main-memory address.
- out_memWData  out  DATA_W  main-memory write data.
- inp_memAck  in  1  one-cycle completion pulse from main memory.
- inp_memRData  in  DATA_W  read data, valid with inp_memAck.
- out_missCount  out  16  saturating count of read misses.

Behaviour:
- Storage: per line valid bit, tag, and data.
  - Index = inp_address[INDEX_BITS-1:0].
  - Lookup hit = valid & tag match.
- Reset (inp_rst=1 at a rising edge):
  - All valid bits cleared, state=IDLE, out_missCount=0, capture register=0.
  - Outputs during and after reset: out_memReq=0, out_memWe=0, out_hit=1, out_readMem=0.
  - A request in flight is abandoned. No line is written. An inp_memAck arriving afterwards is ignored.
- Read/write priority: if inp_memRead and inp_memWrite are both 1, the access is treated as a store.
- IDLE state:
  - No access: out_hit=1, out_readMem=0.
  - Read hit: out_hit=1, out_readMem=line data, combinationally in the same cycle (0 extra latency).
  - Read miss: out_hit=0 → RD_MISS. out_missCount increments at this edge, saturating at 16'hFFFF.
  - Store (hit or miss): out_hit=0 → WR_THRU.
- RD_MISS state:
  - out_memReq=1, out_memWe=0, out_memAddr=inp_address, out_hit=0.
  - On inp_memAck: line[index] ← {valid=1, tag, inp_memRData}; capture register ← inp_memRData; → DONE.
  - A conflicting line is overwritten; no writeback is needed (write-through).
- WR_THRU state:
  - out_memReq=1, out_memWe=1, out_memAddr=inp_address, out_memWData=inp_writeData, out_hit=0.
  - On inp_memAck: if the line is a tag hit, line data ← inp_writeData. On a miss the line is untouched (no-allocate). Capture register ← 0. → DONE.
- DONE state:
  - Lasts exactly one cycle. out_hit=1, out_memReq=0, out_readMem=capture register (0 for stores) → IDLE.
  - MEM/RB latches on the falling edge inside DONE; the pipeline presents the next access in the following cycle.
- Handshake rules:
  - out_memReq, out_memAddr, out_memWe and out_memWData are held constant from the first request cycle until the ack cycle inclusive.
  - out_memReq drops in the cycle after ack.
  - An ack in the same cycle the request is first raised is legal; that gives a miss penalty of 2 cycles (1 req cycle + DONE).
  - inp_memAck is ignored in IDLE and DONE.
- Input stability: inp_address, inp_writeData, inp_memRead and inp_memWrite must be stable while out_hit=0. The block does not re-sample them mid-miss.
- out_missCount counts read misses only, never stores.

Test Plan:
- Reset, then load addr 16'h0012 with ack after 3 cycles returning 16'hBEEF → out_hit low 3 cycles, memReq/addr held; DONE cycle shows out_hit=1 and out_readMem=16'hBEEF; out_missCount=1.
- Repeat load 16'h0012 → out_hit=1 in the same cycle, out_readMem=16'hBEEF, no memReq, out_missCount still 1.
- Store 16'h1234 to 16'h0012 (hit) → memReq/memWe=1 until ack, then out_hit=1. A following load returns 16'h1234 with no memReq.
- Store to 16'h0033 (miss), then load 16'h0033 → store does not allocate; the load misses (out_missCount increments) and gets ack data.
- Load 16'h001A, which has the same index as 16'h0012 but a different tag → miss, line replaced. A subsequent load of 16'h0012 misses again.
- Reset asserted in the middle of RD_MISS, then ack pulses 2 cycles later → memReq=0 the cycle after reset, ack ignored, all lines invalid, out_hit=1, out_missCount=0.
